// File: rtl/idma_rd_2d_cmd_gen_if.sv
// Descriptor, read-command and status bundle between the 2-D read sequencer
// (master) and the channel/control environment (slave).
interface idma_rd_2d_cmd_gen_if #(
  parameter int unsigned AXI_ADDR_WID = 32,
  parameter int unsigned ROW_CNT_WID  = 16
);
  localparam int unsigned WORD_WID = 32;

  logic                    cfg_start;
  logic [AXI_ADDR_WID-1:0] cfg_base_addr;
  logic [WORD_WID-1:0]     cfg_row_words;
  logic [AXI_ADDR_WID-1:0] cfg_row_stride;
  logic [ROW_CNT_WID-1:0]  cfg_row_cnt;
  logic                    cfg_abort;
  logic                    rd_req;
  logic [AXI_ADDR_WID-1:0] rd_addr;
  logic [WORD_WID-1:0]     rd_num;
  logic                    rd_addr_ready;
  logic                    rd_data_hs;
  logic                    busy;
  logic                    done;
  logic                    cfg_err;

  modport master (
    input  cfg_start, cfg_base_addr, cfg_row_words, cfg_row_stride, cfg_row_cnt, cfg_abort,
    input  rd_addr_ready, rd_data_hs,
    output rd_req, rd_addr, rd_num, busy, done, cfg_err
  );

  modport slave (
    output cfg_start, cfg_base_addr, cfg_row_words, cfg_row_stride, cfg_row_cnt, cfg_abort,
    output rd_addr_ready, rd_data_hs,
    input  rd_req, rd_addr, rd_num, busy, done, cfg_err
  );
endinterface

// File: rtl/idma_rd_2d_cmd_gen.sv
// 2-D read command sequencer: one rd_req per row of a strided descriptor, bounded
// rows in flight, beat counting on returned data, done pulse after the last beat.
module idma_rd_2d_cmd_gen #(
  parameter int unsigned AXI_ADDR_WID = 32,
  parameter int unsigned ROW_CNT_WID  = 16,
  parameter int unsigned MAX_OUTSTD   = 4
) (
  input logic                  aclk,
  input logic                  aresetn,
  idma_rd_2d_cmd_gen_if.master cmd
);

  localparam int unsigned WORD_WID = 32;
  localparam logic [ROW_CNT_WID-1:0] MAX_OUT = ROW_CNT_WID'(MAX_OUTSTD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [AXI_ADDR_WID-1:0] rd_addr_q;
  logic [AXI_ADDR_WID-1:0] stride_q;
  logic [WORD_WID-1:0]     rd_num_q;
  logic [WORD_WID-1:0]     beat_cnt_q;
  logic [ROW_CNT_WID-1:0]  row_cnt_q;
  logic [ROW_CNT_WID-1:0]  issued_q;
  logic [ROW_CNT_WID-1:0]  issued_inc;
  logic [ROW_CNT_WID-1:0]  drained_q;
  logic [ROW_CNT_WID-1:0]  drained_d;
  logic                    abort_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    cfg_err_q;
  logic                    cfg_ok;
  logic                    start_acc;
  logic                    beat_act;
  logic                    row_done;
  logic                    push;

  assign cfg_ok     = (cmd.cfg_row_words != '0) && (cmd.cfg_row_cnt != '0);
  assign start_acc  = (state_q == S_IDLE) && cmd.cfg_start && cfg_ok;
  assign beat_act   = cmd.rd_data_hs && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
  assign row_done   = beat_act && (beat_cnt_q == (rd_num_q - WORD_WID'(1)));
  assign drained_d  = drained_q + ROW_CNT_WID'(row_done);
  assign issued_inc = issued_q + ROW_CNT_WID'(1);

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and push decision; outstanding check sees drained before this cycle's beat
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_acc) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        push = cmd.rd_addr_ready && ((issued_q - drained_q) < MAX_OUT) &&
               !abort_q && !cmd.cfg_abort;
        if (abort_q || cmd.cfg_abort) begin
          state_d = S_DRAIN;
        end else if (push && (issued_inc == row_cnt_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained_d == issued_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Descriptor latch, address walk and row/beat accounting
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_addr_q  <= '0;
      stride_q   <= '0;
      rd_num_q   <= '0;
      row_cnt_q  <= '0;
      issued_q   <= '0;
      drained_q  <= '0;
      beat_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      if (start_acc) begin
        rd_addr_q  <= cmd.cfg_base_addr;
        stride_q   <= cmd.cfg_row_stride;
        rd_num_q   <= cmd.cfg_row_words;
        row_cnt_q  <= cmd.cfg_row_cnt;
        issued_q   <= '0;
        drained_q  <= '0;
        beat_cnt_q <= '0;
      end else begin
        if (push) begin
          issued_q  <= issued_inc;
          rd_addr_q <= rd_addr_q + stride_q;
        end
        if (row_done) begin
          beat_cnt_q <= '0;
          drained_q  <= drained_d;
        end else if (beat_act) begin
          beat_cnt_q <= beat_cnt_q + WORD_WID'(1);
        end
      end
      if (state_q == S_IDLE) begin
        abort_q <= 1'b0;
      end else if (cmd.cfg_abort) begin
        abort_q <= 1'b1;
      end
    end
  end

  // Status flops; busy stays high through the done cycle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      cfg_err_q <= cmd.cfg_start && ((state_q != S_IDLE) || !cfg_ok);
    end
  end

  assign cmd.rd_req  = push;
  assign cmd.rd_addr = rd_addr_q;
  assign cmd.rd_num  = rd_num_q;
  assign cmd.busy    = busy_q;
  assign cmd.done    = done_q;
  assign cmd.cfg_err = cfg_err_q;

endmodule
